// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and defaults for the PC / fetch / decode blocks.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_HOLD  = 2'd2,
    FS_FAULT = 2'd3
  } fs_state_t;

  // Instruction fetches must land on a word boundary.
  function automatic logic is_word_aligned(input logic [1:0] i_lsbs);
    return (i_lsbs == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timeout_ctr
// Brief    : 8-bit saturating wait counter; flags expiry at TIMEOUT-1.
// Revision : 1.0  initial release
// ============================================================================
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] C_MAX  = 8'hFF;

  logic [7:0] r_count;

  // Count cycles spent waiting for the memory; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != C_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage: PC -> imem req/ack -> instruction register with
//            PC+4 presented to decode under valid/ready, sticky fault flag.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              busy,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_fault
);

  localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(WORD_BYTES);

  fs_state_t r_state;
  logic      w_aligned;
  logic      w_ctr_clr;
  logic      w_ctr_en;
  logic      w_expired;

  assign w_aligned = is_word_aligned(pc_in[1:0]);

  // The wait counter only runs while a request is outstanding and unanswered;
  // every other state holds it at zero so each new REQ starts from 0.
  assign w_ctr_clr = flush || (r_state != FS_REQ) || imem_ack;
  assign w_ctr_en  = (r_state == FS_REQ) && !imem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk      (CLK),
    .rst      (Reset),
    .i_clr    (w_ctr_clr),
    .i_en     (w_ctr_en),
    .o_expired(w_expired)
  );

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state     <= FS_IDLE;
      busy        <= 1'b0;
      imem_addr   <= '0;
      imem_req    <= 1'b0;
      ir_out      <= '0;
      pc_plus4    <= '0;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (flush) begin
      // Abort everything; ir_out/pc_plus4 deliberately keep their values.
      r_state     <= FS_IDLE;
      busy        <= 1'b0;
      imem_req    <= 1'b0;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (pc_valid) begin
            busy <= 1'b1;
            if (w_aligned) begin
              imem_addr <= pc_in;
              imem_req  <= 1'b1;
              r_state   <= FS_REQ;
            end else begin
              fetch_fault <= 1'b1;
              r_state     <= FS_FAULT;
            end
          end
        end
        FS_REQ: begin
          if (imem_ack) begin
            ir_out   <= imem_rdata;
            pc_plus4 <= imem_addr + C_STEP;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            r_state  <= FS_HOLD;
          end else if (w_expired) begin
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
            r_state     <= FS_FAULT;
          end
        end
        FS_HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            if (pc_valid && w_aligned) begin
              imem_addr <= pc_in;
              imem_req  <= 1'b1;
              r_state   <= FS_REQ;
            end else if (pc_valid) begin
              // A misaligned follow-on fetch faults exactly as it would from IDLE.
              fetch_fault <= 1'b1;
              r_state     <= FS_FAULT;
            end else begin
              busy    <= 1'b0;
              r_state <= FS_IDLE;
            end
          end
        end
        FS_FAULT: begin
          fetch_fault <= 1'b1;
          ir_valid    <= 1'b0;
          imem_req    <= 1'b0;
        end
        default: begin
          r_state <= FS_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
